// File: rtl/coder_2_4_pending_encoder.sv
// Sequential 4->2 encoder: accepts a request vector, then emits one binary index
// per set bit over a valid/ready stream, lowest-first or round-robin from the last index.
module coder_2_4_pending_encoder #(
    parameter int IDX_W       = 2,
    parameter int REQ_W       = 4,
    parameter int ROUND_ROBIN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    input  logic [REQ_W-1:0] req_i,
    output logic             req_ready_o,
    output logic             idx_valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             idx_last_o,
    input  logic             idx_ready_i,
    output logic             zero_req_o
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [REQ_W-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic             zero_req_q, zero_req_d;

    logic [IDX_W-1:0] search_start;
    logic [IDX_W-1:0] rot_pos [REQ_W];
    logic [REQ_W-1:0] rot_pending;
    logic [IDX_W-1:0] sel_off;
    logic [IDX_W-1:0] sel_idx;
    logic [REQ_W-1:0] clr_mask;
    logic             single_bit;
    logic             in_drain;

    // Fixed priority is round-robin with the search pinned to bit 0.
    assign search_start = (ROUND_ROBIN != 0) ? IDX_W'(last_idx_q + 1'b1) : '0;

    // pending rotated so that rot_pending[0] is the first candidate position;
    // REQ_W is a power of two so the IDX_W-bit add wraps naturally.
    generate
        for (genvar gi = 0; gi < REQ_W; gi++) begin : g_rot
            assign rot_pos[gi]     = search_start + IDX_W'(gi);
            assign rot_pending[gi] = pending_q[rot_pos[gi]];
        end
    endgenerate

    always_comb begin
        sel_off = '0;
        for (int k = REQ_W - 1; k >= 0; k--) begin
            if (rot_pending[k]) begin
                sel_off = IDX_W'(k);
            end
        end
    end

    assign sel_idx = search_start + sel_off;

    generate
        for (genvar gi = 0; gi < REQ_W; gi++) begin : g_clr
            assign clr_mask[gi] = (sel_idx == IDX_W'(gi));
        end
    endgenerate

    assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - 1'b1)) == '0);
    assign in_drain   = (state_q == ST_DRAIN);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        last_idx_d = last_idx_q;
        zero_req_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_i != '0) begin
                        pending_d = req_i;
                        state_d   = ST_DRAIN;
                    end else begin
                        zero_req_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (idx_ready_i) begin
                    pending_d  = pending_q & ~clr_mask;
                    last_idx_d = sel_idx;
                    if (single_bit) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            pending_q  <= '0;
            last_idx_q <= IDX_W'(REQ_W - 1);
            zero_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_idx_q <= last_idx_d;
            zero_req_q <= zero_req_d;
        end
    end

    // Outputs depend only on registered state, never directly on req_i.
    assign req_ready_o = (state_q == ST_IDLE);
    assign idx_valid_o = in_drain;
    assign idx_o       = in_drain ? sel_idx : '0;
    assign idx_last_o  = in_drain & single_bit;
    assign zero_req_o  = zero_req_q;

endmodule

// File: tb/tb_coder_2_4_pending_encoder.sv
// Bench for coder_2_4_pending_encoder: a fixed-priority and a round-robin instance
// run in lockstep against a queue-based reference of the emission order.
module tb_coder_2_4_pending_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req = 4'd0;
    logic       idx_ready = 1'b0;

    logic       f_req_ready, f_idx_valid, f_idx_last, f_zero_req;
    logic [1:0] f_idx;
    logic       r_req_ready, r_idx_valid, r_idx_last, r_zero_req;
    logic [1:0] r_idx;

    int n_cmp = 0;
    int n_err = 0;
    int last_rr = 3;
    int exp_f[$];
    int exp_r[$];

    always #5 clk = ~clk;

    coder_2_4_pending_encoder #(.IDX_W(2), .REQ_W(4), .ROUND_ROBIN(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_i(req),
        .req_ready_o(f_req_ready), .idx_valid_o(f_idx_valid), .idx_o(f_idx),
        .idx_last_o(f_idx_last), .idx_ready_i(idx_ready), .zero_req_o(f_zero_req)
    );

    coder_2_4_pending_encoder #(.IDX_W(2), .REQ_W(4), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_i(req),
        .req_ready_o(r_req_ready), .idx_valid_o(r_idx_valid), .idx_o(r_idx),
        .idx_last_o(r_idx_last), .idx_ready_i(idx_ready), .zero_req_o(r_zero_req)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag, input logic [31:0] ready_exp);
        chk({tag, "_f_ready"}, 32'(f_req_ready), ready_exp);
        chk({tag, "_r_ready"}, 32'(r_req_ready), ready_exp);
        chk({tag, "_f_valid"}, 32'(f_idx_valid), 32'd0);
        chk({tag, "_r_valid"}, 32'(r_idx_valid), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_quiet(tag, 32'd0);
        chk({tag, "_f_idx"},  32'(f_idx), 32'd0);
        chk({tag, "_r_idx"},  32'(r_idx), 32'd0);
        chk({tag, "_f_last"}, 32'(f_idx_last), 32'd0);
        chk({tag, "_r_last"}, 32'(r_idx_last), 32'd0);
        chk({tag, "_f_zero"}, 32'(f_zero_req), 32'd0);
        chk({tag, "_r_zero"}, 32'(r_zero_req), 32'd0);
    endtask

    // Reference: fixed priority emits set bits in ascending order; round-robin emits
    // the same ascending list rotated to begin at the first bit >= last_rr+1.
    task automatic build_model(input logic [3:0] vec);
        int k;
        int n;
        exp_f.delete();
        exp_r.delete();
        for (int b = 0; b < 4; b++) if (vec[b]) exp_f.push_back(b);
        n = exp_f.size();
        k = 0;
        for (int j = n - 1; j >= 0; j--) if (exp_f[j] >= (last_rr + 1) % 4) k = j;
        for (int j = 0; j < n; j++) exp_r.push_back(exp_f[(j + k) % n]);
        if (n > 0) last_rr = exp_r[n - 1];
    endtask

    task automatic accept(input logic [3:0] vec);
        build_model(vec);
        chk("pre_f_ready", 32'(f_req_ready), 32'd1);
        chk("pre_r_ready", 32'(r_req_ready), 32'd1);
        req_valid = 1'b1;
        req = vec;
        tick();
        req_valid = 1'b0;
        req = 4'($urandom);
    endtask

    task automatic check_idx(input int i);
        int n;
        n = exp_f.size();
        chk("f_valid", 32'(f_idx_valid), 32'd1);
        chk("r_valid", 32'(r_idx_valid), 32'd1);
        chk("f_idx", 32'(f_idx), 32'(exp_f[i]));
        chk("r_idx", 32'(r_idx), 32'(exp_r[i]));
        chk("f_last", 32'(f_idx_last), 32'(i == n - 1));
        chk("r_last", 32'(r_idx_last), 32'(i == n - 1));
        chk("f_ready_drain", 32'(f_req_ready), 32'd0);
        chk("r_ready_drain", 32'(r_req_ready), 32'd0);
    endtask

    task automatic run_vector(input logic [3:0] vec, input int stall_first, input bit rand_ready);
        int stall;
        int low_run;
        bit hs;
        accept(vec);
        if (exp_f.size() == 0) begin
            chk("zv_f_zero", 32'(f_zero_req), 32'd1);
            chk("zv_r_zero", 32'(r_zero_req), 32'd1);
            chk_quiet("zv", 32'd1);
            tick();
            chk("zv_f_zero_end", 32'(f_zero_req), 32'd0);
            chk("zv_r_zero_end", 32'(r_zero_req), 32'd0);
            chk_quiet("zv_end", 32'd1);
            $display("vec=%b zero_req pulse", vec);
            return;
        end
        stall = stall_first;
        for (int i = 0; i < exp_f.size(); i++) begin
            low_run = 0;
            hs = 1'b0;
            while (!hs) begin
                if (stall > 0) idx_ready = 1'b0;
                else if (rand_ready) idx_ready = (low_run >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
                else idx_ready = 1'b1;
                check_idx(i);
                hs = idx_ready;
                tick();
                if (stall > 0) stall--;
                if (!hs) low_run++;
            end
        end
        idx_ready = 1'b0;
        chk_quiet("post", 32'd1);
        $display("vec=%b fixed=%p rr=%p", vec, exp_f, exp_r);
    endtask

    initial begin
        logic [3:0] rv;

        // Power-on reset
        tick();
        tick();
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_quiet("init", 32'd0);
        tick();
        tick();
        chk_quiet("idle", 32'd1);

        // One-hot sweep, multi-hot, backpressure
        run_vector(4'b0001, 0, 1'b0);
        run_vector(4'b0010, 0, 1'b0);
        run_vector(4'b0100, 0, 1'b0);
        run_vector(4'b1000, 0, 1'b0);
        run_vector(4'b1011, 0, 1'b0);
        run_vector(4'b0110, 3, 1'b0);
        run_vector(4'b1111, 0, 1'b0);
        run_vector(4'b0000, 0, 1'b0);

        // Randomized vectors with random downstream stalls
        for (int t = 0; t < 40; t++) begin
            rv = 4'($urandom);
            run_vector(rv, 0, 1'b1);
        end

        // Reset in the middle of draining 1111
        accept(4'b1111);
        idx_ready = 1'b1;
        check_idx(0);
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        tick();
        tick();
        chk_all_zero("mid_rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        idx_ready = 1'b0;
        last_rr = 3;
        #1;
        chk_quiet("mid_init", 32'd0);
        tick();
        tick();
        chk_quiet("mid_idle", 32'd1);
        $display("reset mid-drain: outputs cleared, no stale idx");

        // Round-robin sequence from the reset value of last_idx
        run_vector(4'b1111, 0, 1'b0);
        run_vector(4'b0011, 0, 1'b0);
        run_vector(4'b0001, 0, 1'b0);
        run_vector(4'b0011, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
